// File: rtl/register_arbiter_pkg.sv
// Shared definitions for the register arbiter: FSM state encoding and the
// helper used to size the owner index.
package register_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    ACK   = 2'b10
  } state_t;

  // Smallest r with 2**r >= v; usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/register_arbiter_if.sv
// Request/grant bundle between the producers and the arbiter.
interface register_arbiter_if
  import register_arbiter_pkg::*;
#(
  parameter int N = 10,
  parameter int M = 4
);
  localparam int W = clog2(M);

  logic [M-1:0]   req;
  logic [M*N-1:0] data;
  logic [M-1:0]   gnt;
  logic [M-1:0]   ack;
  logic [W-1:0]   owner;
  logic           busy;
  logic [N-1:0]   q;

  // Producer side
  modport master (
    output req, data,
    input  gnt, ack, owner, busy, q
  );

  // Arbiter side
  modport slave (
    input  req, data,
    output gnt, ack, owner, busy, q
  );
endinterface

// File: rtl/register_arbiter_register.sv
// Shared storage register: loads d when ena is high, cleared by an
// asynchronous active-high reset.
module register_arbiter_register #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  input  logic         ena,
  output logic [N-1:0] q
);
  logic [N-1:0] q_reg;

  // Load on enable, clear immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_reg <= '0;
    else if (ena) q_reg <= d;
  end

  assign q = q_reg;
endmodule

// File: rtl/register_arbiter.sv
// Round-robin write controller: grants one requester at a time, commits its
// word into the shared register and returns a one-cycle acknowledge.
module register_arbiter
  import register_arbiter_pkg::*;
#(
  parameter int N = 10,
  parameter int M = 4
) (
  input logic               clk,
  input logic               rst,   // asynchronous, active low
  register_arbiter_if.slave bus
);
  localparam int W = clog2(M);
  localparam logic [M-1:0] ONE_HOT0 = M'(1);

  state_t         state_reg;
  logic [W-1:0]   ptr_reg;
  logic [W-1:0]   owner_reg;
  logic [M-1:0]   gnt_reg;
  logic [M-1:0]   ack_reg;
  logic [W-1:0]   winner;
  logic [W-1:0]   ptr_next;
  logic [N-1:0]   words [M];
  logic [N-1:0]   wr_word;
  logic [N-1:0]   q_word;

  // First requester at or after p, wrapping modulo M; lowest offset wins.
  function automatic logic [W-1:0] rr_pick(input logic [M-1:0] r,
                                           input logic [W-1:0] p);
    logic [W-1:0] win;
    int idx;
    win = p;
    for (int i = M - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % M;
      if (r[idx]) win = W'(idx);
    end
    return win;
  endfunction

  for (genvar gi = 0; gi < M; gi++) begin : g_words
    assign words[gi] = bus.data[gi*N +: N];
  end

  assign winner   = rr_pick(bus.req, ptr_reg);
  assign ptr_next = (owner_reg == W'(M - 1)) ? '0 : owner_reg + 1'b1;
  assign wr_word  = words[owner_reg];

  // Arbitration FSM with registered grant/acknowledge/owner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      gnt_reg   <= '0;
      ack_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          ack_reg <= '0;
          gnt_reg <= '0;
          if (|bus.req) begin
            owner_reg <= winner;
            gnt_reg   <= ONE_HOT0 << winner;
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          gnt_reg   <= '0;
          ack_reg   <= ONE_HOT0 << owner_reg;
          state_reg <= ACK;
        end
        ACK: begin
          ack_reg   <= '0;
          ptr_reg   <= ptr_next;
          state_reg <= IDLE;
        end
        default: begin
          gnt_reg   <= '0;
          ack_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  register_arbiter_register #(.N(N)) u_register (
    .clk (clk),
    .rst (~rst),
    .d   (wr_word),
    .ena (state_reg == WRITE),
    .q   (q_word)
  );

  assign bus.gnt   = gnt_reg;
  assign bus.ack   = ack_reg;
  assign bus.owner = owner_reg;
  assign bus.busy  = (state_reg != IDLE);
  assign bus.q     = q_word;
endmodule

// File: doc/register_arbiter.md
# register_arbiter

Round-robin write controller that shares one N-bit `register` instance among M requesters. Each requester raises a request with its data word; the controller grants one requester at a time, commits that word into the shared register, and returns a one-cycle acknowledge. It sits between independent producer blocks and the shared storage register, and is the only block allowed to drive the register's `d` and `ena`.

## Interface
- `N`, 10, data width of the shared register
- `M`, 4, number of requesters (2..8)
- `W`, derived localparam = clog2(M) (2 for M=4), width of owner index; not overridable

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  M  request per requester; bit i high = requester i wants to write
- `data`  in  M*N  write words; requester i occupies `data[i*N +: N]`
- `gnt`  out  M  one-hot grant, registered
- `ack`  out  M  one-hot write-done pulse, registered, one cycle
- `owner`  out  W  index of current/last granted requester
- `busy`  out  1  high whenever FSM is not IDLE
- `q`  out  N  shared register contents

## Operation
- FSM states: IDLE, WRITE, ACK.
- IDLE: if any `req` bit high, select winner = first set bit scanning ptr, ptr+1, … mod M; at edge: `owner`<=winner, `gnt[winner]`<=1, go WRITE. No request: stay IDLE, outputs unchanged except `gnt`/`ack` = 0.
- WRITE: register `d` = `data[owner]`, `ena` = 1 (combinational from state); at edge: `q` loads word, `gnt`<=0, `ack[owner]`<=1, go ACK.
- ACK: `ena` = 0; at edge: `ack`<=0, ptr<=(owner+1) mod M, go IDLE.
- `ena` is 0 in IDLE and ACK; register holds `q`.
- Requester contract: hold `req` and its data stable from request until `ack` seen; drop `req` at the edge ending the `ack` cycle. A `req` still high in the following IDLE is a new request.
- `req` changes during WRITE/ACK do not affect the current transaction; only IDLE samples `req`.
- Round-robin pointer guarantees a continuously requesting requester waits at most M-1 transactions.
- Reset (async, `rst`=0): state IDLE, ptr=0, `owner`=0, `gnt`=0, `ack`=0, `busy`=0, `q`=0 (register reset driven with ~`rst`). Reset mid-WRITE/ACK aborts: no `ack` issued, `q` cleared, pending requests re-arbitrate from ptr=0 after release.

## Timing
- Request sampled at edge k (IDLE): `gnt`/`busy` high after edge k; `q` = new word and `ack` high after edge k+1; `gnt` low after edge k+1; `ack`/`busy` low after edge k+2.
- One write per 3 cycles maximum throughput; back-to-back requests: next grant issued at edge k+3.
- `gnt` and `ack` never overlap and are never high for two requesters at once.
- `owner` valid from grant through ACK and holds its value in IDLE.
- First request after reset release granted at the first rising edge with `rst`=1 and `req`≠0.

## Structure
- Header `register_arbiter_defs.vh`: state encodings IDLE=2'b00, WRITE=2'b01, ACK=2'b10, and a constant clog2 function for `W`.
- One sub-module: existing `register` (parameter `N`), ports `clk`, `rst`=~`rst`, `d`=`data[owner]`, `ena`=(state==WRITE), `q`.
- Round-robin selection as a function inside `register_arbiter`; no separate module.

## Test plan
- Reset with `req`=4'b1111, all data = 10'h3FF -> `q`=0, `gnt`=`ack`=0, `busy`=0, `owner`=0 throughout reset.
- Single request: `req`=4'b0100, data[2]=10'h155 -> `gnt`=4'b0100 one cycle, then `q`=10'h155 with `ack`=4'b0100 one cycle, `busy` high exactly 2 cycles.
- All four requesting continuously (data i = 10'h100+i) after reset -> grant order 0,1,2,3,0; `q` sequence 10'h100,101,102,103,100; grants spaced 3 cycles.
- Pointer wrap: after requester 3 served, `req`=4'b1001 -> requester 0 granted before 3.
- Request change during WRITE: drop `req[1]`, raise `req[2]` mid-transaction -> transaction for 1 completes with its `ack`; 2 served next.
- `rst` asserted during WRITE -> `q`=0 immediately, no `ack` pulse; after release with `req`=4'b0010 -> requester 1 granted on first edge.
